// File: rtl/touch_button_pkg.sv
// rtl/touch_button_pkg.sv - shared mode encodings and width helper
// Purpose: constants and helpers shared by the touch-button LED array.
// Contents:
//   MODE_TOGGLE / MODE_MOMENTARY - per-channel LED mode encodings
//   clog2_min1()                 - counter width for a threshold, at least 1 bit
package touch_button_pkg;

  localparam logic MODE_TOGGLE    = 1'b0;
  localparam logic MODE_MOMENTARY = 1'b1;

  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/touch_button_channel.sv
// rtl/touch_button_channel.sv - one touch-pad channel: sync, debounce, hold timer, LED
// Purpose: turns one raw touch-pad level into debounced press/release/long
//          events and drives one LED in toggle or momentary mode.
// Ports:
//   clk_i, rst_i - clock, asynchronous active-high reset
//   touch_i      - raw asynchronous pad level
//   mode_i       - LED mode (MODE_TOGGLE / MODE_MOMENTARY)
//   led_o        - LED drive, 1 = on
//   press_o      - one-cycle pulse on debounced press
//   release_o    - one-cycle pulse on debounced release
//   long_o       - one-cycle pulse when the long-press threshold is reached
module touch_button_channel
  import touch_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 1000,
  parameter int LONG_PRESS_CYCLES  = 25_000_000,
  parameter bit TOUCH_ACTIVE_LEVEL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic touch_i,
  input  logic mode_i,
  output logic led_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int DB_W   = clog2_min1(DEBOUNCE_CYCLES);
  localparam int HOLD_W = clog2_min1(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  // One below the saturation value: the edge that moves the count onto
  // HOLD_LAST is the edge the long pulse is registered on.
  localparam logic [HOLD_W-1:0] HOLD_ARM  = HOLD_W'(LONG_PRESS_CYCLES - 2);
  localparam logic IDLE_LEVEL = ~TOUCH_ACTIVE_LEVEL;

  logic              sync1_q, sync2_q;
  logic              stable_q, stable_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              fired_q, fired_d;
  logic              led_q, led_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              pressed;

  assign pressed = (sync2_q == TOUCH_ACTIVE_LEVEL);

  always_comb begin
    stable_d  = stable_q;
    db_cnt_d  = '0;
    hold_d    = hold_q;
    fired_d   = fired_q;
    led_d     = led_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    if (pressed != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d  = pressed;
        press_d   = pressed;
        release_d = ~pressed;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // Saturating hold timer: at most one long pulse per press.
    if (stable_q) begin
      if (hold_q != HOLD_LAST) begin
        hold_d = hold_q + 1'b1;
      end
      if (hold_q == HOLD_ARM) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end
    end else begin
      hold_d = '0;
    end

    // Toggle logic reads fired_q (the old value) before it is cleared here.
    if (release_d) begin
      fired_d = 1'b0;
    end

    if (mode_i == MODE_MOMENTARY) begin
      led_d = stable_d;
    end else if (release_d) begin
      led_d = fired_q ? 1'b0 : ~led_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= IDLE_LEVEL;
      sync2_q   <= IDLE_LEVEL;
      stable_q  <= 1'b0;
      db_cnt_q  <= '0;
      hold_q    <= '0;
      fired_q   <= 1'b0;
      led_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync1_q   <= touch_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      db_cnt_q  <= db_cnt_d;
      hold_q    <= hold_d;
      fired_q   <= fired_d;
      led_q     <= led_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign led_o     = led_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/touch_button_led_array.sv
// rtl/touch_button_led_array.sv - array of independent touch-button LED channels
// Purpose: replicates touch_button_channel CHANNELS times between the board
//          touch pads and the LED pins, exporting per-channel event pulses.
// Ports:
//   system_clock, system_reset - clock, asynchronous active-high reset
//   touch_button[CHANNELS]     - raw pad levels
//   mode[CHANNELS]             - per-channel LED mode, 0 toggle / 1 momentary
//   led[CHANNELS]              - LED drive
//   press_pulse, release_pulse, long_press_pulse [CHANNELS] - event pulses
module touch_button_led_array
  import touch_button_pkg::*;
#(
  parameter int CHANNELS           = 4,
  parameter int DEBOUNCE_CYCLES    = 1000,
  parameter int LONG_PRESS_CYCLES  = 25_000_000,
  parameter bit TOUCH_ACTIVE_LEVEL = 1'b1
) (
  input  logic                system_clock,
  input  logic                system_reset,
  input  logic [CHANNELS-1:0] touch_button,
  input  logic [CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press_pulse
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
    touch_button_channel #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES  (LONG_PRESS_CYCLES),
      .TOUCH_ACTIVE_LEVEL (TOUCH_ACTIVE_LEVEL)
    ) u_channel (
      .clk_i     (system_clock),
      .rst_i     (system_reset),
      .touch_i   (touch_button[g]),
      .mode_i    (mode[g]),
      .led_o     (led[g]),
      .press_o   (press_pulse[g]),
      .release_o (release_pulse[g]),
      .long_o    (long_press_pulse[g])
    );
  end

endmodule

// File: tb/tb_touch_button_led_array.sv
// tb/tb_touch_button_led_array.sv - scoreboard bench for touch_button_led_array
module tb_touch_button_led_array;

  localparam int DB = 4;
  localparam int LP = 10;
  localparam int DLY = DB + 2;     // raw change to stable flip, in edges
  localparam int LNG = LP - 1;     // press edge to long pulse, in edges

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] touch = 2'b00;
  logic [1:0] mode = 2'b00;
  logic [1:0] led, press, rel, lng;

  int edge_n = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         at;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] l;
    logic [1:0] ld;
  } ev_t;

  ev_t sb[$];

  touch_button_led_array #(
    .CHANNELS           (2),
    .DEBOUNCE_CYCLES    (DB),
    .LONG_PRESS_CYCLES  (LP),
    .TOUCH_ACTIVE_LEVEL (1'b1)
  ) dut (
    .system_clock     (clk),
    .system_reset     (rst),
    .touch_button     (touch),
    .mode             (mode),
    .led              (led),
    .press_pulse      (press),
    .release_pulse    (rel),
    .long_press_pulse (lng)
  );

  always #10 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic expect_ev(input int at, input logic [1:0] p, input logic [1:0] r,
                           input logic [1:0] l, input logic [1:0] ld);
    ev_t e;
    e.at = at; e.p = p; e.r = r; e.l = l; e.ld = ld;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with any event pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (press != 2'b00 || rel != 2'b00 || lng != 2'b00)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: edge=%0d p=%b r=%b l=%b led=%b, expected no event",
                 edge_n, press, rel, lng, led);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (edge_n != e.at || press !== e.p || rel !== e.r || lng !== e.l || led !== e.ld) begin
          errors++;
          $display("FAIL event: got edge=%0d p=%b r=%b l=%b led=%b, expected edge=%0d p=%b r=%b l=%b led=%b",
                   edge_n, press, rel, lng, led, e.at, e.p, e.r, e.l, e.ld);
        end
      end
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;

    // 1. Reset: outputs held at 0 while pads move, then reset mid-press.
    repeat (3) @(negedge clk);
    check("reset_idle", {press, rel, lng, led}, 8'h00);
    touch = 2'b11;
    repeat (3) @(negedge clk);
    touch = 2'b00;
    check("reset_touch_held", {press, rel, lng, led}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    mode = 2'b01;
    n = edge_n;
    touch = 2'b01;
    expect_ev(n + DLY, 2'b01, 2'b00, 2'b00, 2'b01);
    repeat (8) @(negedge clk);
    check("mid_press_led", {6'h00, led}, 8'h01);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {press, rel, lng, led}, 8'h00);
    repeat (2) @(negedge clk);
    n = edge_n;
    rst = 1'b0;
    expect_ev(n + DLY, 2'b01, 2'b00, 2'b00, 2'b01);
    repeat (7) @(negedge clk);
    touch = 2'b00;
    m = edge_n;
    expect_ev(m + DLY, 2'b00, 2'b01, 2'b00, 2'b00);
    repeat (8) @(negedge clk);
    mode = 2'b00;
    repeat (2) @(negedge clk);

    // 2. Short presses in toggle mode: led[0] goes on, then off.
    for (int k = 0; k < 2; k++) begin
      n = edge_n;
      touch = 2'b01;
      expect_ev(n + DLY, 2'b01, 2'b00, 2'b00, (k == 0) ? 2'b00 : 2'b01);
      repeat (6) @(negedge clk);
      touch = 2'b00;
      m = edge_n;
      expect_ev(m + DLY, 2'b00, 2'b01, 2'b00, (k == 0) ? 2'b01 : 2'b00);
      repeat (8) @(negedge clk);
      check("short_press_led", {6'h00, led}, (k == 0) ? 8'h01 : 8'h00);
    end

    // 3. Glitch of 3 clocks is rejected.
    touch = 2'b01;
    repeat (3) @(negedge clk);
    touch = 2'b00;
    repeat (10) @(negedge clk);
    check("glitch_led", {6'h00, led}, 8'h00);

    // 4. ch1: short press to light it, then long press forces it off.
    n = edge_n;
    touch = 2'b10;
    expect_ev(n + DLY, 2'b10, 2'b00, 2'b00, 2'b00);
    repeat (6) @(negedge clk);
    touch = 2'b00;
    m = edge_n;
    expect_ev(m + DLY, 2'b00, 2'b10, 2'b00, 2'b10);
    repeat (8) @(negedge clk);
    check("ch1_lit", {6'h00, led}, 8'h02);
    n = edge_n;
    touch = 2'b10;
    expect_ev(n + DLY, 2'b10, 2'b00, 2'b00, 2'b10);
    expect_ev(n + DLY + LNG, 2'b00, 2'b00, 2'b10, 2'b10);
    repeat (20) @(negedge clk);
    touch = 2'b00;
    m = edge_n;
    expect_ev(m + DLY, 2'b00, 2'b10, 2'b00, 2'b00);
    repeat (8) @(negedge clk);
    check("long_press_led", {6'h00, led}, 8'h00);

    // 5. Momentary mode on ch0.
    mode = 2'b01;
    n = edge_n;
    touch = 2'b01;
    expect_ev(n + DLY, 2'b01, 2'b00, 2'b00, 2'b01);
    repeat (8) @(negedge clk);
    check("momentary_held", {6'h00, led}, 8'h01);
    touch = 2'b00;
    m = edge_n;
    expect_ev(m + DLY, 2'b00, 2'b01, 2'b00, 2'b00);
    repeat (8) @(negedge clk);
    check("momentary_released", {6'h00, led}, 8'h00);

    // 6. Both channels together; ch0 switches momentary -> toggle mid-press.
    n = edge_n;
    touch = 2'b11;
    expect_ev(n + DLY, 2'b11, 2'b00, 2'b00, 2'b01);
    repeat (7) @(negedge clk);
    mode = 2'b00;
    @(negedge clk);
    check("mode_switch_keeps_led", {6'h00, led}, 8'h01);
    touch = 2'b00;
    m = edge_n;
    expect_ev(m + DLY, 2'b00, 2'b11, 2'b00, 2'b10);
    repeat (10) @(negedge clk);
    check("final_led", {6'h00, led}, 8'h02);
    check("scoreboard_drained", 8'(sb.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
